// File: rtl/alu_acc.sv
// alu_acc: accumulator ALU with a valid/ready request port, a registered result
// port with backpressure, and a RUN/HALT state machine.
//
// Ports:
//   clk, rst_              clock, asynchronous active-low reset
//   in_valid/in_ready      request handshake (opcode + data)
//   opcode[2:0], data[W]   operation select and operand
//   resume                 releases the block from HALT
//   out_valid/out_ready    result handshake (result, carry, skip)
//   result[W], carry, skip registered outputs of the last accepted request
//   zero                   accumulator == 0 (combinational from acc register)
//   halted                 state is HALT
module alu_acc #(
  parameter int unsigned WIDTH    = 8,
  parameter logic [63:0] ACC_INIT = 64'd0
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] data,
  input  logic             resume,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             skip,
  output logic             zero,
  output logic             halted
);

  localparam int unsigned    SUM_W   = WIDTH + 1;
  localparam logic [WIDTH-1:0] ACC_RST = ACC_INIT[WIDTH-1:0];

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic               run_c;
  logic               accept_c;
  logic [SUM_W-1:0]   sum_c;

  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic               skip_q, skip_d;
  logic               out_valid_q, out_valid_d;

  // Accept only in RUN and when the output slot is empty or draining this edge.
  assign in_ready = run_c && (!out_valid_q || out_ready);
  assign accept_c = in_valid && in_ready;

  // Full-width sum so bit WIDTH is the carry-out.
  assign sum_c = SUM_W'(acc_q) + SUM_W'(data);

  // State register.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; resume is ignored in RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (accept_c && (opcode == OP_HLT)) state_d = ST_HALT;
      ST_HALT: if (resume)                         state_d = ST_RUN;
    endcase
  end

  // State decode outputs.
  always_comb begin
    run_c  = 1'b0;
    halted = 1'b0;
    if (state_q == ST_RUN) run_c  = 1'b1;
    else                   halted = 1'b1;
  end

  // Datapath and output-slot next values.
  always_comb begin
    acc_d       = acc_q;
    result_d    = result_q;
    carry_d     = carry_q;
    skip_d      = skip_q;
    out_valid_d = out_valid_q && !out_ready;
    if (accept_c) begin
      out_valid_d = 1'b1;
      carry_d     = 1'b0;
      skip_d      = 1'b0;
      result_d    = acc_q;
      case (opcode)
        OP_ADD: begin
          acc_d    = sum_c[WIDTH-1:0];
          result_d = sum_c[WIDTH-1:0];
          carry_d  = sum_c[WIDTH];
        end
        OP_AND: begin
          acc_d    = acc_q & data;
          result_d = acc_q & data;
        end
        OP_XOR: begin
          acc_d    = acc_q ^ data;
          result_d = acc_q ^ data;
        end
        OP_LDA: begin
          acc_d    = data;
          result_d = data;
        end
        OP_SKZ: skip_d = (acc_q == '0);
        // HLT, STO, JMP: result is the unchanged accumulator.
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      acc_q       <= ACC_RST;
      result_q    <= '0;
      carry_q     <= 1'b0;
      skip_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      skip_q      <= skip_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign skip      = skip_q;
  assign zero      = (acc_q == '0);

endmodule

// File: tb/tb_alu_acc.sv
// tb_alu_acc: scoreboard bench for alu_acc (WIDTH=8 main instance, WIDTH=1 corner instance).
module tb_alu_acc;

  localparam int unsigned W = 8;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  logic         clk = 1'b0;
  logic         rst_;
  logic         in_valid, in_ready;
  logic [2:0]   opcode;
  logic [W-1:0] data;
  logic         resume;
  logic         out_valid, out_ready;
  logic [W-1:0] result;
  logic         carry, skip, zero, halted;

  logic         w1_in_valid, w1_in_ready;
  logic [2:0]   w1_opcode;
  logic [0:0]   w1_data;
  logic         w1_resume;
  logic         w1_out_valid, w1_out_ready;
  logic [0:0]   w1_result;
  logic         w1_carry, w1_skip, w1_zero, w1_halted;

  typedef struct packed {
    logic [W-1:0] result;
    logic         carry;
    logic         skip;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_acc #(.WIDTH(W), .ACC_INIT(64'd0)) dut (
    .clk(clk), .rst_(rst_), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .data(data), .resume(resume), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .carry(carry), .skip(skip),
    .zero(zero), .halted(halted)
  );

  alu_acc #(.WIDTH(1), .ACC_INIT(64'd1)) dut_w1 (
    .clk(clk), .rst_(rst_), .in_valid(w1_in_valid), .in_ready(w1_in_ready),
    .opcode(w1_opcode), .data(w1_data), .resume(w1_resume), .out_valid(w1_out_valid),
    .out_ready(w1_out_ready), .result(w1_result), .carry(w1_carry), .skip(w1_skip),
    .zero(w1_zero), .halted(w1_halted)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every transfer on the output port pops one expected entry.
  always @(negedge clk) begin
    if (rst_ && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got result 0x%0h expected no output", result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_result", 64'(result), 64'(e.result));
        chk("sb_carry",  64'(carry),  64'(e.carry));
        chk("sb_skip",   64'(skip),   64'(e.skip));
      end
    end
  end

  // Issue one request (called just after a rising edge); push expected at acceptance.
  task automatic send(input logic [2:0] op, input logic [W-1:0] d,
                      input logic [W-1:0] er, input logic ec, input logic es);
    int   n;
    exp_t e;
    n        = 0;
    in_valid = 1'b1;
    opcode   = op;
    data     = d;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready got 0 expected 1 (op %0d)", op);
    end else begin
      e.result = er;
      e.carry  = ec;
      e.skip   = es;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ = 1'b1; in_valid = 1'b0; opcode = '0; data = '0; resume = 1'b0; out_ready = 1'b1;
    w1_in_valid = 1'b0; w1_opcode = '0; w1_data = '0; w1_resume = 1'b0; w1_out_ready = 1'b0;
    #2 rst_ = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result",    64'(result),    64'd0);
    chk("rst_carry",     64'(carry),     64'd0);
    chk("rst_skip",      64'(skip),      64'd0);
    chk("rst_zero",      64'(zero),      64'd1);
    chk("rst_halted",    64'(halted),    64'd0);
    chk("rst_w1_zero",   64'(w1_zero),   64'd0);
    repeat (3) @(posedge clk);
    #1 rst_ = 1'b1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Load then add with carry-out.
    send(OP_LDA, 8'hF0, 8'hF0, 1'b0, 1'b0);
    send(OP_ADD, 8'h20, 8'h10, 1'b1, 1'b0);
    chk("zero_after_add", 64'(zero), 64'd0);

    // XOR to zero, then SKZ sets skip.
    send(OP_LDA, 8'h5A, 8'h5A, 1'b0, 1'b0);
    send(OP_XOR, 8'h5A, 8'h00, 1'b0, 1'b0);
    chk("zero_after_xor", 64'(zero), 64'd1);
    send(OP_SKZ, 8'h00, 8'h00, 1'b0, 1'b1);

    // AND, pass-through opcodes, SKZ on non-zero.
    send(OP_LDA, 8'h0F, 8'h0F, 1'b0, 1'b0);
    send(OP_AND, 8'h3C, 8'h0C, 1'b0, 1'b0);
    send(OP_STO, 8'h00, 8'h0C, 1'b0, 1'b0);
    send(OP_JMP, 8'h55, 8'h0C, 1'b0, 1'b0);
    send(OP_SKZ, 8'hFF, 8'h0C, 1'b0, 1'b0);

    // Backpressure: hold the ADD result for several cycles, then back-to-back.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(OP_ADD, 8'h01, 8'h0D, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready",  64'(in_ready),  64'd0);
      chk("bp_result",    64'(result),    64'h0D);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(OP_ADD, 8'hF3, 8'h00, 1'b1, 1'b0);

    // resume in RUN does nothing.
    resume = 1'b1;
    @(posedge clk); #1;
    resume = 1'b0;
    chk("run_resume_halted", 64'(halted), 64'd0);

    // HALT: requests blocked until resume; acc preserved.
    send(OP_LDA, 8'h07, 8'h07, 1'b0, 1'b0);
    send(OP_HLT, 8'hAA, 8'h07, 1'b0, 1'b0);
    chk("hlt_halted",   64'(halted),   64'd1);
    chk("hlt_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1; opcode = OP_LDA; data = 8'hFF;
    repeat (2) begin
      @(negedge clk);
      chk("halt_in_ready", 64'(in_ready), 64'd0);
      chk("halt_halted",   64'(halted),   64'd1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    resume = 1'b1;
    @(posedge clk); #1;
    resume = 1'b0;
    chk("resume_halted",   64'(halted),   64'd0);
    chk("resume_in_ready", 64'(in_ready), 64'd1);
    send(OP_ADD, 8'h01, 8'h08, 1'b0, 1'b0);

    // Reset with a pending, un-taken result.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(OP_LDA, 8'h33, 8'h33, 1'b0, 1'b0);
    @(negedge clk);
    chk("pend_out_valid", 64'(out_valid), 64'd1);
    #2 rst_ = 1'b0;
    sb.delete();
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_result",    64'(result),    64'd0);
    chk("midrst_zero",      64'(zero),      64'd1);
    @(posedge clk); #1;
    rst_ = 1'b1;
    out_ready = 1'b1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    send(OP_ADD, 8'h05, 8'h05, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'd0);

    // WIDTH=1 instance: ADD 1 on acc=1 wraps with carry.
    w1_in_valid = 1'b1; w1_opcode = OP_ADD; w1_data = 1'b1;
    @(negedge clk);
    chk("w1_in_ready", 64'(w1_in_ready), 64'd1);
    @(posedge clk); #1;
    w1_in_valid = 1'b0;
    chk("w1_out_valid", 64'(w1_out_valid), 64'd1);
    chk("w1_result",    64'(w1_result),    64'd0);
    chk("w1_carry",     64'(w1_carry),     64'd1);
    chk("w1_zero",      64'(w1_zero),      64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_acc.md
ALU_ACC -- requirements
Module: alu_acc

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the accumulator, data and result width in bits (legal range 1..64).
REQ-002 Parameter ACC_INIT, default 0, SHALL set the accumulator value loaded at reset, truncated to WIDTH bits.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_valid  input  1  SHALL mark opcode and data as a valid operation request.
REQ-006 in_ready  output  1  SHALL indicate the block accepts a request this cycle.
REQ-007 opcode  input  3  SHALL select the operation: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
REQ-008 data  input  WIDTH  SHALL be the operand.
REQ-009 resume  input  1  SHALL release the block from HALT.
REQ-010 out_valid  output  1  SHALL mark result, carry and skip as valid.
REQ-011 out_ready  input  1  SHALL indicate the consumer takes the result this cycle.
REQ-012 result  output  WIDTH  SHALL be the registered operation result.
REQ-013 carry  output  1  SHALL be the registered carry-out of the last accepted ADD.
REQ-014 skip  output  1  SHALL be the registered skip flag of the last accepted SKZ.
REQ-015 zero  output  1  SHALL be high exactly when the current accumulator equals 0 (combinational from the accumulator register).
REQ-016 halted  output  1  SHALL be high while the state is HALT.

Function
REQ-017 A request SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-018 in_ready SHALL equal (state==RUN) && (!out_valid || out_ready).
REQ-019 Latency SHALL be one cycle: out_valid rises on the edge that accepts the request.
REQ-020 out_valid SHALL stay high, with result/carry/skip held stable, until the edge where out_ready is high; it then clears unless a new request is accepted on that same edge.
REQ-021 ADD SHALL set acc and result to (acc + data) mod 2^WIDTH, with carry = bit WIDTH of the full sum.
REQ-022 AND, XOR and LDA SHALL set acc and result to acc&data, acc^data and data respectively, with carry = 0.
REQ-023 SKZ SHALL set result = acc, skip = (acc==0) and leave acc unchanged.
REQ-024 HLT, STO and JMP SHALL set result = acc and leave acc unchanged.
REQ-025 skip SHALL be cleared by every accepted non-SKZ opcode; carry SHALL be cleared by every accepted non-ADD opcode.
REQ-026 zero SHALL reflect the accumulator as updated, i.e. it changes on the acceptance edge.
REQ-027 The state machine SHALL have two states, RUN and HALT; RUN->HALT on acceptance of HLT; HALT->RUN on a rising edge with resume high.
REQ-028 In HALT, in_ready SHALL be 0; a pending HLT result SHALL still drain through out_valid/out_ready.
REQ-029 resume while in RUN SHALL have no effect.
REQ-030 Opcode values are fully decoded; no request SHALL leave acc, flags or state undefined.

Reset
REQ-031 While rst_ is low: acc=ACC_INIT, state=RUN, out_valid=0, result=0, carry=0, skip=0, asynchronously.
REQ-032 Reset asserted mid-transaction SHALL discard any pending result; the first request accepted after release SHALL operate on ACC_INIT.
REQ-033 in_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-034 WIDTH=8: LDA 0xF0, ADD 0x20 with out_ready=1 -> results 0xF0 then 0x10, carry 0 then 1, zero 0.
REQ-035 WIDTH=8: LDA 0x5A, XOR 0x5A, SKZ -> results 0x5A, 0x00, 0x00; zero=1 after XOR; skip=1 on the SKZ result.
REQ-036 Backpressure: out_ready=0 for 3 cycles after ADD accepted -> in_ready=0, result stable, out_valid=1; out_ready=1 with a new request on the same edge -> back-to-back transfer, no loss.
REQ-037 HLT accepted -> halted=1, in_ready=0 until resume pulse; next ADD 0x01 operates on the unchanged acc.
REQ-038 Reset asserted while out_valid=1 and out_ready=0 -> out_valid=0 immediately, acc=ACC_INIT; WIDTH=1 build: ADD 1 on acc=1 -> result 0, carry 1.
